// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: single read/write transaction engine for the RTC mux AD bus.
// Optional: define RTC_READBACK_EN to verify each write with an automatic read.
module rtc_bus_cycle #(
    parameter int PH_CYCLES = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              ad_sel,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    localparam int            CW   = $clog2(PH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic              fin_q;
    logic              fin_d;
    logic              vfy_q;
    logic              vfy_d;
    logic              rw_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              sample;
    logic              rd_cyc;
    logic              ph_end;

    logic              cs_n_d;
    logic              rd_n_d;
    logic              wr_n_d;
    logic              ad_sel_d;
    logic              ad_oe_d;
    logic [DATA_W-1:0] ad_out_d;

    assign ph_end  = (cnt_q == LAST);
    assign cnt_inc = ph_end ? '0 : cnt_q + 1'b1;
    // The readback pass reuses the read data phase of a write transaction.
    assign rd_cyc  = rw_q | vfy_q;

    // State and phase counter register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            vfy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            vfy_q   <= vfy_d;
        end
    end

    // Next-state logic: each bus phase lasts PH_CYCLES clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = 1'b0;
        vfy_d   = vfy_q;
        accept  = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    accept  = 1'b1;
                    vfy_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d = cnt_inc;
                if (ph_end) state_d = S_GAP1;
            end
            S_GAP1: begin
                cnt_d = cnt_inc;
                if (ph_end) state_d = S_DATA;
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (ph_end) begin
                    state_d = S_GAP2;
                    sample  = rd_cyc;
                end
            end
            S_GAP2: begin
                cnt_d = cnt_inc;
                if (ph_end) begin
`ifdef RTC_READBACK_EN
                    if (!rw_q && !vfy_q) begin
                        state_d = S_ADDR;
                        vfy_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin strobe decode for the current phase, registered below.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        unique case (state_q)
            S_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            S_GAP1: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            S_DATA: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b1;
                if (rd_cyc) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Request latch, loaded only when a start is accepted in IDLE.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Registered pin outputs, status and read data capture.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_sel <= 1'b0;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rdata  <= '0;
        end else begin
            cs_n   <= cs_n_d;
            rd_n   <= rd_n_d;
            wr_n   <= wr_n_d;
            ad_sel <= ad_sel_d;
            ad_oe  <= ad_oe_d;
            ad_out <= ad_out_d;
            busy   <= (state_d != S_IDLE);
            done   <= fin_q;
            if (sample) rdata <= ad_in;
        end
    end

`ifdef RTC_READBACK_EN
    // Write-verify result, updated together with done.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (fin_q && vfy_q) begin
            err <= (rdata != wdata_q);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb_rtc_bus_cycle: scoreboard bench for the RTC bus-cycle engine.
// Cycle c means the clock period following the c-th edge after accept.
module tb_rtc_bus_cycle;

    localparam int PH = 4;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic          rw    = 1'b0;
    logic [DW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] ad_in = '0;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          cs_n;
    logic          rd_n;
    logic          wr_n;
    logic          ad_sel;
    logic [DW-1:0] ad_out;
    logic          ad_oe;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp   = 0;
    int            n_bad   = 0;
    logic          m_err   = 1'b0;

    rtc_bus_cycle #(
        .PH_CYCLES(PH),
        .DATA_W   (DW)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .cs_n  (cs_n),
        .rd_n  (rd_n),
        .wr_n  (wr_n),
        .ad_sel(ad_sel),
        .ad_out(ad_out),
        .ad_oe (ad_oe),
        .ad_in (ad_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of cycle 0.
    task automatic issue(input logic r, input logic [DW-1:0] a,
                         input logic [DW-1:0] d);
        rw    = r;
        addr  = a;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected {cs_n, rd_n, wr_n, ad_oe, ad_sel} for one lone transaction.
    function automatic logic [4:0] exp_strobes(input logic rd, input int c);
        if (c < 1 || c > 4 * PH) return 5'b11100;
        case ((c - 1) / PH)
            0:       return 5'b01010;
            1:       return 5'b01110;
            2:       return rd ? 5'b00101 : 5'b01011;
            default: return 5'b11100;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cs_n, rd_n, wr_n, ad_sel, ad_oe, busy, done, err} !== 8'b1110_0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {cs_n, rd_n, wr_n, ad_sel, ad_oe, busy, done, err}, 8'b1110_0000);
        end
        n_cmp++;
        if (ad_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ad_out: got %h want 00", ad_out);
        end
        n_cmp++;
        if (rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        Reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read(input logic [DW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   ndone = 0;
        e.rdata = d;
        e.err   = m_err;
        sb.push_back(e);
        ad_in = 8'hFF;
        issue(1'b1, a, 8'h00);
        for (int c = 1; c <= 19; c++) begin
            tick();
            n_cmp++;
            if ({cs_n, rd_n, wr_n, ad_oe, ad_sel} !== exp_strobes(1'b1, c)) begin
                n_bad++;
                $display("FAIL read_strobes c=%0d: got %b want %b", c,
                         {cs_n, rd_n, wr_n, ad_oe, ad_sel}, exp_strobes(1'b1, c));
            end
            if (c <= 2 * PH) begin
                n_cmp++;
                if (ad_out !== a) begin
                    n_bad++;
                    $display("FAIL read_addr c=%0d: got %h want %h", c, ad_out, a);
                end
            end
            n_cmp++;
            if (ad_oe === 1'b1 && rd_n === 1'b0) begin
                n_bad++;
                $display("FAIL contention c=%0d: got oe=1 rd_n=0 want not both", c);
            end
            n_cmp++;
            if (done !== (c == 4 * PH + 1)) begin
                n_bad++;
                $display("FAIL read_done c=%0d: got %b want %b", c, done, c == 4 * PH + 1);
            end
            if (done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL read_sb c=%0d: got done want no done", c);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata || err !== e.err) begin
                        n_bad++;
                        $display("FAIL read_data c=%0d: got %h/%b want %h/%b",
                                 c, rdata, err, e.rdata, e.err);
                    end
                end
            end
            if (c == 10) ad_in = d;
            if (c == 13) ad_in = 8'hFF;
        end
        n_cmp++;
        if (rdata !== d) begin
            n_bad++;
            $display("FAIL read_hold: got %h want %h", rdata, d);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL read_ndone: got %0d want 1", ndone);
        end
    endtask

`ifndef RTC_READBACK_EN
    task automatic test_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
        exp_t          e;
        int            ndone = 0;
        logic [DW-1:0] keep;
        keep    = rdata;
        e.rdata = keep;
        e.err   = 1'b0;
        sb.push_back(e);
        ad_in = 8'hC3;
        issue(1'b0, a, d);
        for (int c = 1; c <= 19; c++) begin
            tick();
            n_cmp++;
            if ({cs_n, rd_n, wr_n, ad_oe, ad_sel} !== exp_strobes(1'b0, c)) begin
                n_bad++;
                $display("FAIL write_strobes c=%0d: got %b want %b", c,
                         {cs_n, rd_n, wr_n, ad_oe, ad_sel}, exp_strobes(1'b0, c));
            end
            if (c >= 1 && c <= 3 * PH) begin
                n_cmp++;
                if (ad_out !== ((c <= 2 * PH) ? a : d)) begin
                    n_bad++;
                    $display("FAIL write_ad_out c=%0d: got %h want %h", c,
                             ad_out, (c <= 2 * PH) ? a : d);
                end
            end
            if (c <= 4 * PH - 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL write_busy c=%0d: got %b want 1", c, busy);
                end
            end
            n_cmp++;
            if (done !== (c == 4 * PH + 1)) begin
                n_bad++;
                $display("FAIL write_done c=%0d: got %b want %b", c, done, c == 4 * PH + 1);
            end
            if (done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL write_sb c=%0d: got done want no done", c);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata || err !== e.err) begin
                        n_bad++;
                        $display("FAIL write_rdata c=%0d: got %h/%b want %h/%b",
                                 c, rdata, err, e.rdata, e.err);
                    end
                end
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL write_idle_busy c=%0d: got %b want 0", c, busy);
                end
            end
        end
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL write_ndone: got %0d want 1", ndone);
        end
    endtask
`endif

    task automatic test_ignore();
        exp_t e;
        int   ndone = 0;
        e.rdata = 8'h5A;
        e.err   = m_err;
        sb.push_back(e);
        ad_in = 8'h5A;
        issue(1'b1, 8'h10, 8'h00);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 3 || c == 10) begin
                start = 1'b1;
                rw    = 1'b0;
                addr  = 8'hEE;
            end else begin
                start = 1'b0;
            end
            if (c == 6) begin
                n_cmp++;
                if (ad_out !== 8'h10) begin
                    n_bad++;
                    $display("FAIL ignore_addr: got %h want 10", ad_out);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL ignore_sb c=%0d: got done want no done", c);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata || c != 4 * PH + 1) begin
                        n_bad++;
                        $display("FAIL ignore_done c=%0d: got %h want %h at c=17",
                                 c, rdata, e.rdata);
                    end
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL ignore_ndone: got %0d want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ndone = 0;
        logic want;
        e.rdata = 8'h66;
        e.err   = m_err;
        for (int i = 0; i < 3; i++) sb.push_back(e);
        ad_in = 8'h66;
        rw    = 1'b1;
        addr  = 8'h26;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 60; c++) begin
            tick();
            want = (c == 17 || c == 34 || c == 51);
            n_cmp++;
            if (done !== want) begin
                n_bad++;
                $display("FAIL b2b_done c=%0d: got %b want %b", c, done, want);
            end
            if (c == 18 || c == 35) begin
                n_cmp++;
                if (cs_n !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_cs c=%0d: got %b want 0", c, cs_n);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_sb c=%0d: got extra done want none", c);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata) begin
                        n_bad++;
                        $display("FAIL b2b_rdata c=%0d: got %h want %h", c, rdata, e.rdata);
                    end
                end
            end
            if (c == 34) start = 1'b0;
        end
        n_cmp++;
        if (ndone != 3) begin
            n_bad++;
            $display("FAIL b2b_ndone: got %0d want 3", ndone);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        ad_in = 8'h00;
        issue(1'b0, 8'h33, 8'h77);
        for (int c = 1; c <= 10; c++) tick();
        n_cmp++;
        if (wr_n !== 1'b0 || ad_oe !== 1'b1 || ad_sel !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got wr_n=%b oe=%b sel=%b want 0 1 1", wr_n, ad_oe, ad_sel);
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({cs_n, wr_n, rd_n, ad_oe, busy, done} !== 6'b111000) begin
            n_bad++;
            $display("FAIL mid_release: got %b want 111000",
                     {cs_n, wr_n, rd_n, ad_oe, busy, done});
        end
        m_err = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0 || cs_n !== 1'b1 || rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_after: got done=%0d cs_n=%b rdata=%h want 0 1 00",
                     ndone, cs_n, rdata);
        end
        test_read(8'h26, 8'h81);
    endtask

`ifdef RTC_READBACK_EN
    task automatic test_readback();
        exp_t          e;
        logic [DW-1:0] v;
        int            ndone;
        for (int p = 0; p < 2; p++) begin
            v       = (p == 0) ? 8'h44 : 8'h45;
            ndone   = 0;
            m_err   = (v != 8'h45);
            e.rdata = v;
            e.err   = m_err;
            sb.push_back(e);
            ad_in = v;
            issue(1'b0, 8'h21, 8'h45);
            for (int c = 1; c <= 36; c++) begin
                tick();
                n_cmp++;
                if (done !== (c == 8 * PH + 1)) begin
                    n_bad++;
                    $display("FAIL rb_done p=%0d c=%0d: got %b want %b",
                             p, c, done, c == 8 * PH + 1);
                end
                if (c <= 8 * PH - 1) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL rb_busy p=%0d c=%0d: got %b want 1", p, c, busy);
                    end
                end
                if (c == 26) begin
                    n_cmp++;
                    if ({rd_n, ad_oe, ad_sel, cs_n} !== 4'b0010) begin
                        n_bad++;
                        $display("FAIL rb_read p=%0d: got %b want 0010",
                                 p, {rd_n, ad_oe, ad_sel, cs_n});
                    end
                end
                if (done === 1'b1) begin
                    ndone++;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL rb_sb p=%0d c=%0d: got done want none", p, c);
                    end else begin
                        e = sb.pop_front();
                        if (rdata !== e.rdata || err !== e.err) begin
                            n_bad++;
                            $display("FAIL rb_result p=%0d: got %h/%b want %h/%b",
                                     p, rdata, err, e.rdata, e.err);
                        end
                    end
                end
            end
            n_cmp++;
            if (ndone != 1 || err !== m_err) begin
                n_bad++;
                $display("FAIL rb_hold p=%0d: got n=%0d err=%b want 1 %b",
                         p, ndone, err, m_err);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read(8'h26, 8'h37);
`ifndef RTC_READBACK_EN
        test_write(8'h21, 8'h45);
`endif
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef RTC_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
